// File: rtl/uartwb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uartwb_pkg
// Brief   : Command-frame constants, host state encoding and frame byte mux.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package uartwb_pkg;

   localparam logic [7:0] CMD_READ   = 8'h00;
   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam int         FRAME_LEN  = 9;
   localparam int         RSP_LEN_WR = 1;
   localparam int         RSP_LEN_RD = 5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } host_state_e;

   // Byte idx of the outgoing frame; reads carry zero dummies in the data slots.
   function automatic logic [7:0] frame_byte(input logic        we,
                                             input logic [31:0] addr,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = we ? CMD_WRITE : CMD_READ;
         4'd1:    b = addr[31:24];
         4'd2:    b = addr[23:16];
         4'd3:    b = addr[15:8];
         4'd4:    b = addr[7:0];
         4'd5:    b = we ? wdata[31:24] : 8'h00;
         4'd6:    b = we ? wdata[23:16] : 8'h00;
         4'd7:    b = we ? wdata[15:8]  : 8'h00;
         4'd8:    b = we ? wdata[7:0]   : 8'h00;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uartrx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uartrx
// Brief   : 8N1 UART receiver; valid rises with each byte, drops at next start.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module uartrx #(
   parameter int BAUD_PER = 10
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       valid
);
   localparam int            BW          = $clog2(BAUD_PER + 1);
   localparam logic [BW-1:0] c_baud_last = BW'(BAUD_PER - 1);
   localparam logic [BW-1:0] c_half_last = BW'((BAUD_PER > 1) ? (BAUD_PER / 2 - 1) : 0);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   rx_state_e     st_q;
   logic [1:0]    sync_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;
   logic [7:0]    dout_q;
   logic          valid_q;
   logic          w_rx;

   assign w_rx = sync_q[1];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         st_q    <= RX_IDLE;
         sync_q  <= 2'b11;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rx};
         case (st_q)
            RX_IDLE: begin
               baud_q <= '0;
               if (en && !w_rx) st_q <= RX_START;
            end
            RX_START: begin
               // Re-check at mid start bit so glitches are not taken as frames.
               if (baud_q == c_half_last) begin
                  baud_q <= '0;
                  bit_q  <= '0;
                  if (!w_rx) begin
                     st_q    <= RX_DATA;
                     valid_q <= 1'b0;
                  end else begin
                     st_q <= RX_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            RX_DATA: begin
               if (baud_q == c_baud_last) begin
                  baud_q <= '0;
                  sh_q   <= {w_rx, sh_q[7:1]};
                  if (bit_q == 3'd7) st_q <= RX_STOP;
                  else               bit_q <= bit_q + 3'd1;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            RX_STOP: begin
               if (baud_q == c_baud_last) begin
                  baud_q <= '0;
                  st_q   <= RX_IDLE;
                  if (w_rx) begin
                     dout_q  <= sh_q;
                     valid_q <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: st_q <= RX_IDLE;
         endcase
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/uarttx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uarttx
// Brief   : 8N1 UART transmitter, data LSB first, BAUD_PER clocks per bit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module uarttx #(
   parameter int BAUD_PER = 10
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en,
   input  logic [7:0] din,
   output logic       ready,
   output logic       tx
);
   localparam int            BW          = $clog2(BAUD_PER + 1);
   localparam logic [BW-1:0] c_baud_last = BW'(BAUD_PER - 1);

   logic          busy_q;
   logic          tx_q;
   logic [8:0]    sh_q;
   logic [3:0]    bit_q;
   logic [BW-1:0] baud_q;

   // bit_q counts start(0), data(1..8), stop(9) periods.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         busy_q <= 1'b0;
         tx_q   <= 1'b1;
         sh_q   <= '0;
         bit_q  <= '0;
         baud_q <= '0;
      end else if (!busy_q) begin
         if (en) begin
            busy_q <= 1'b1;
            tx_q   <= 1'b0;
            sh_q   <= {1'b1, din};
            bit_q  <= '0;
            baud_q <= '0;
         end
      end else if (baud_q != c_baud_last) begin
         baud_q <= baud_q + BW'(1);
      end else begin
         baud_q <= '0;
         if (bit_q == 4'd9) begin
            busy_q <= 1'b0;
         end else begin
            tx_q  <= sh_q[0];
            sh_q  <= {1'b1, sh_q[8:1]};
            bit_q <= bit_q + 4'd1;
         end
      end
   end

   assign ready = ~busy_q;
   assign tx    = tx_q;

endmodule
`default_nettype wire

// File: rtl/uartwb_host_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uartwb_host_fsm
// Brief   : Frame sequencer, byte handshake, response assembler and timeout.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module uartwb_host_fsm
   import uartwb_pkg::*;
#(
   parameter int TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [7:0]  rsp_status_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_timeout_o,
   output logic        tx_en_o,
   output logic [7:0]  tx_din_o,
   input  logic        tx_ready_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_dout_i
);
   localparam int            TW          = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT - 1);
   localparam logic [3:0]    c_last_idx  = 4'(FRAME_LEN - 1);
   localparam logic [2:0]    c_len_wr    = 3'(RSP_LEN_WR);
   localparam logic [2:0]    c_len_rd    = 3'(RSP_LEN_RD);

   host_state_e   state_q;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    idx_q;
   logic [3:0]    idx_d;
   logic          pend_q;
   logic          skip_q;
   logic [2:0]    exp_q;
   logic [TW-1:0] tmo_q;
   logic          rx_prev_q;
   logic          rx_take_q;
   logic          tx_en_q;
   logic [7:0]    tx_din_q;
   logic          rsp_valid_q;
   logic [7:0]    rsp_status_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_timeout_q;

   assign idx_d       = idx_q + 4'd1;
   assign req_ready_o = nrst & (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q       <= ST_IDLE;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         idx_q         <= '0;
         pend_q        <= 1'b0;
         skip_q        <= 1'b0;
         exp_q         <= '0;
         tmo_q         <= '0;
         rx_prev_q     <= 1'b1;
         rx_take_q     <= 1'b0;
         tx_en_q       <= 1'b0;
         tx_din_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_status_q  <= '0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         rx_prev_q   <= rx_valid_i;
         rx_take_q   <= rx_valid_i & ~rx_prev_q;
         tx_en_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  we_q          <= req_we_i;
                  addr_q        <= req_addr_i;
                  wdata_q       <= req_wdata_i;
                  idx_q         <= '0;
                  rsp_status_q  <= '0;
                  rsp_rdata_q   <= '0;
                  rsp_timeout_q <= 1'b0;
                  skip_q        <= 1'b0;
                  pend_q        <= 1'b0;
                  state_q       <= ST_SEND;
                  // Issue byte 0 right away to shorten accept-to-start latency.
                  if (tx_ready_i) begin
                     tx_en_q  <= 1'b1;
                     tx_din_q <= frame_byte(req_we_i, req_addr_i, req_wdata_i, 4'd0);
                     pend_q   <= 1'b1;
                     skip_q   <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               // skip_q masks the cycle where the transmitter's ready still lags.
               if (skip_q) begin
                  skip_q <= 1'b0;
               end else if (!pend_q) begin
                  if (tx_ready_i) begin
                     tx_en_q  <= 1'b1;
                     tx_din_q <= frame_byte(we_q, addr_q, wdata_q, idx_q);
                     pend_q   <= 1'b1;
                     skip_q   <= 1'b1;
                  end
               end else if (tx_ready_i) begin
                  pend_q <= 1'b0;
                  if (idx_q == c_last_idx) begin
                     state_q <= ST_WAIT_RSP;
                     idx_q   <= '0;
                     tmo_q   <= '0;
                     exp_q   <= we_q ? c_len_wr : c_len_rd;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            ST_WAIT_RSP: begin
               if (rx_take_q) begin
                  tmo_q <= '0;
                  idx_q <= idx_d;
                  if (idx_q == 4'd0) rsp_status_q <= rx_dout_i;
                  else               rsp_rdata_q  <= {rsp_rdata_q[23:0], rx_dout_i};
                  if (idx_d[2:0] == exp_q) begin
                     state_q       <= ST_DONE;
                     rsp_valid_q   <= 1'b1;
                     rsp_timeout_q <= 1'b0;
                  end
               end else if (tmo_q == c_tmo_last) begin
                  state_q       <= ST_DONE;
                  rsp_valid_q   <= 1'b1;
                  rsp_timeout_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_en_o       = tx_en_q;
   assign tx_din_o      = tx_din_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_status_o  = rsp_status_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_timeout_o = rsp_timeout_q;

endmodule
`default_nettype wire

// File: rtl/uartwb_host.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uartwb_host
// Brief   : UART command-frame initiator driving a remote uartwb_top bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module uartwb_host
   import uartwb_pkg::*;
#(
   parameter int BAUD_PER = 10,
   parameter int TIMEOUT  = 100000
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_status,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        uart_tx,
   input  logic        uart_rx
);
   logic       w_tx_en;
   logic [7:0] w_tx_din;
   logic       w_tx_ready;
   logic       w_rx_valid;
   logic [7:0] w_rx_dout;

   uartwb_host_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk           (clk),
      .nrst          (nrst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_we_i      (req_we),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_status_o  (rsp_status),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_timeout_o (rsp_timeout),
      .tx_en_o       (w_tx_en),
      .tx_din_o      (w_tx_din),
      .tx_ready_i    (w_tx_ready),
      .rx_valid_i    (w_rx_valid),
      .rx_dout_i     (w_rx_dout)
   );

   uarttx #(
      .BAUD_PER (BAUD_PER)
   ) u_tx (
      .clk   (clk),
      .nrst  (nrst),
      .en    (w_tx_en),
      .din   (w_tx_din),
      .ready (w_tx_ready),
      .tx    (uart_tx)
   );

   uartrx #(
      .BAUD_PER (BAUD_PER)
   ) u_rx (
      .clk   (clk),
      .nrst  (nrst),
      .en    (1'b1),
      .rx    (uart_rx),
      .dout  (w_rx_dout),
      .valid (w_rx_valid)
   );

endmodule
`default_nettype wire

// File: doc/uartwb_host.md
# uartwb_host

UART command-frame initiator: the far-end counterpart of `uartwb_top`. It accepts a parallel read/write request, serializes it as the 9-byte bridge command frame on `uart_tx`, then collects the bridge's response bytes from `uart_rx` and returns status and read data. It lets one FPGA drive a remote `uartwb_top` Wishbone bus, and it serves as a synthesizable traffic generator for bridge regression.

## Interface
- `BAUD_PER`, default 10: clocks per UART bit; passed unchanged to the `uarttx`/`uartrx` instances.
- `TIMEOUT`, default 100000: max clocks to wait for each expected response byte.
- `clk` in 1: clock.
- `nrst` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: Wishbone address.
- `req_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse; the response fields are valid in that cycle.
- `rsp_status` out 8: first response byte received.
- `rsp_rdata` out 32: read data, assembled MSB first.
- `rsp_timeout` out 1: this response ended by timeout.
- `uart_tx` out 1: serial command line to the bridge's `uart_rx`.
- `uart_rx` in 1: serial response line from the bridge's `uart_tx`.

## Operation
- **States:** IDLE, SEND, WAIT_RSP, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch we/addr/wdata, clear byte index and `rsp_rdata`, go to SEND.
- **SEND: frame order**
  - byte 0 = {7'b0, we}
  - bytes 1-4 = addr[31:24], [23:16], [15:8], [7:0]
  - bytes 5-8 = wdata, MSB first; for reads, bytes 5-8 = 0x00 dummies
- **SEND: handshake per byte**
  - Pulse `tx_en` for exactly one cycle with `din` = current byte, only when `tx_ready` = 1 and no byte is already outstanding.
  - Ignore `tx_ready` for the following cycle, because ready may lag.
  - Then wait for `tx_ready` = 1 before issuing the next byte.
  - After byte 8 is issued and `tx_ready` returns, go to WAIT_RSP with expected count = 1 (write) or 5 (read).
- **Receive path**
  - `uartrx` `en` is tied to 1.
  - A byte is taken on the rising edge of its `valid`. The edge-detect register resets to 1, so a `valid` already high out of reset is not a byte.
  - Bytes arriving in IDLE, SEND or DONE are discarded.
- **WAIT_RSP**
  - Received byte 0 goes to `rsp_status`.
  - Received bytes 1-4 shift into `rsp_rdata` MSB first: rdata <= {rdata[23:0], byte}.
  - When the expected count is reached, go to DONE with `rsp_timeout` = 0.
- **Timeout**
  - A counter clears on WAIT_RSP entry and on each received byte, and increments every cycle otherwise.
  - On reaching TIMEOUT-1, go to DONE with `rsp_timeout` = 1.
  - `rsp_status`/`rsp_rdata` hold whatever was assembled so far (zeros for bytes never received).
- **DONE**
  - `rsp_valid` = 1 for one cycle, then IDLE.
  - `rsp_status`, `rsp_rdata` and `rsp_timeout` hold their values until the next request is accepted.

## Timing
- **Reset:** while `nrst` = 0 at a clock edge:
  - state = IDLE; byte index and timeout counter = 0.
  - `req_ready`, `rsp_valid`, `rsp_timeout` = 0; `rsp_status`, `rsp_rdata` = 0.
  - `uart_tx` = 1 (uarttx idle).
  - `req_ready` = 1 in the first cycle after release.
- **Reset mid-operation:** reset in any state aborts the transaction. No `rsp_valid` is produced, and the frame being sent may be truncated.
- **Request acceptance:**
  - `req_ready` is combinational from state, so it is 1 only in IDLE.
  - A request held through SEND/WAIT_RSP is accepted only in the IDLE cycle after DONE.
  - `req_valid` and `rsp_valid` are never both effective in the same cycle.
- **Latency (accept to first start bit):** 1–2 cycles.
- **Frame time:** about 9 × 10 × BAUD_PER clocks plus per-byte handshake cycles.
- **Response:** `rsp_valid` asserts 2 cycles after the rising `valid` of the last expected byte (edge register, then DONE).
- **Counter width:** $clog2(TIMEOUT+1); no wrap-around, because the counter saturates by terminating the state.

## Structure
- Shared package `uartwb_pkg`:
  - CMD_READ = 8'h00, CMD_WRITE = 8'h01, FRAME_LEN = 9, RSP_LEN_WR = 1, RSP_LEN_RD = 5.
  - State encoding typedef.
  - The same constants are consumed by `uartwb_top`.
- Reuse the existing `uarttx` and `uartrx` as the byte engines.
- One new sub-module, `uartwb_host_fsm`: the sequencer, byte mux, response assembler and timeout counter. `uartwb_host` is the wrapper around `uartwb_host_fsm` plus the two UART instances.

## Test plan
All scenarios use `uartwb_host` → `uartwb_top` → `wb_dummy_slave` with BAUD_PER = 10, plus a `uartrx` monitor on `uart_tx`.

- **Read frame format:** read addr 0x00000002 → monitor captures exactly 00 00 00 00 02 00 00 00 00; then one `rsp_valid` with `rsp_timeout` = 0.
- **Write frame and response:** write addr 3, data 0xABCD1234 → frame 01 00 00 00 03 AB CD 12 34; `rsp_valid` after exactly 1 response byte.
- **Read-back:** then read addr 3 → `rsp_rdata` = 0xABCD1234, `rsp_timeout` = 0, `rsp_valid` high exactly one cycle.
- **Timeout:** TIMEOUT = 2000, `uart_rx` held at 1, read issued → `rsp_timeout` = 1, `rsp_rdata` = 0, `rsp_valid` 2000 ± 2 cycles after the last `tx_ready`.
- **Back-to-back requests:** `req_valid` held high with two different requests → second accepted only in the cycle after the first `rsp_valid`; no byte overlap on `uart_tx`.
- **Reset mid-frame:** `nrst` pulsed low during byte 4 of a write → no `rsp_valid`, `req_ready` = 1 after release, and the next read completes normally.
